// File: rtl/iob_cache_line_fill_pkg.sv
// Shared cache configuration: line-fill FSM encodings and default cache geometry.
package iob_cache_line_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } fill_state_e;

  localparam int N_WAYS_DEF        = 8;
  localparam int SET_INDEX_W_DEF   = 7;
  localparam int TAG_W_DEF         = 20;
  localparam int WORD_OFFSET_W_DEF = 2;
  localparam int DATA_W_DEF        = 32;

  // A one-word line still needs a 1-bit beat counter register.
  function automatic int cnt_width(input int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/iob_cache_bin_to_onehot.sv
// Binary way index to one-hot way vector, purely combinational.
module iob_cache_bin_to_onehot #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] bin_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = N'(1) << bin_i;
  end

endmodule

// File: rtl/iob_cache_line_fill.sv
// Cache miss line fill: burst-read one line from the backend into the chosen way, then commit tag and LRU.
// Request is held until be_ready_i; beats are written the cycle they arrive; cke_i=0 freezes state and strobes.
module iob_cache_line_fill
  import iob_cache_line_fill_pkg::*;
#(
  parameter int N_WAYS        = N_WAYS_DEF,
  parameter int NWAYS_W       = $clog2(N_WAYS),
  parameter int SET_INDEX_W   = SET_INDEX_W_DEF,
  parameter int TAG_W         = TAG_W_DEF,
  parameter int WORD_OFFSET_W = WORD_OFFSET_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  localparam int BE_ADDR_W    = TAG_W + SET_INDEX_W + WORD_OFFSET_W
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     rst_i,
  input  logic                     miss_i,
  input  logic [TAG_W-1:0]         miss_tag_i,
  input  logic [SET_INDEX_W-1:0]   miss_index_i,
  input  logic [NWAYS_W-1:0]       way_select_bin_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     be_valid_o,
  output logic [BE_ADDR_W-1:0]     be_addr_o,
  input  logic                     be_ready_i,
  input  logic                     be_rvalid_i,
  input  logic [DATA_W-1:0]        be_rdata_i,
  output logic                     data_we_o,
  output logic [NWAYS_W-1:0]       data_way_o,
  output logic [SET_INDEX_W-1:0]   data_index_o,
  output logic [WORD_OFFSET_W-1:0] data_offset_o,
  output logic [DATA_W-1:0]        data_wdata_o,
  output logic                     tag_we_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     rep_write_en_o,
  output logic [N_WAYS-1:0]        rep_way_hit_o
);

  localparam int CNT_W = cnt_width(WORD_OFFSET_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << WORD_OFFSET_W) - 1);

  fill_state_e             state_q, state_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [SET_INDEX_W-1:0]  index_q, index_d;
  logic [NWAYS_W-1:0]      way_q, way_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    beat;
  logic                    commit_stb;
  logic [N_WAYS-1:0]       way_onehot;

  iob_cache_bin_to_onehot #(
    .N (N_WAYS),
    .W (NWAYS_W)
  ) u_way_onehot (
    .bin_i    (way_q),
    .onehot_o (way_onehot)
  );

  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    index_d        = index_q;
    way_d          = way_q;
    cnt_d          = cnt_q;
    beat           = 1'b0;
    commit_stb     = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    be_valid_o     = (state_q == ST_REQ);
    be_addr_o      = BE_ADDR_W'({tag_q, index_q}) << WORD_OFFSET_W;
    data_way_o     = way_q;
    data_index_o   = index_q;
    tag_o          = tag_q;
    data_wdata_o   = (state_q == ST_FILL) ? be_rdata_i : '0;

    if (cke_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (miss_i) begin
            state_d = ST_REQ;
            tag_d   = miss_tag_i;
            index_d = miss_index_i;
            way_d   = way_select_bin_i;
            cnt_d   = '0;
          end
        end
        ST_REQ: begin
          if (be_ready_i) state_d = ST_FILL;
        end
        ST_FILL: begin
          if (be_rvalid_i) begin
            beat = 1'b1;
            // Counter parks on the last beat; the FSM leaves FILL instead of wrapping.
            if (cnt_q == LAST_BEAT) state_d = ST_COMMIT;
            else                    cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          commit_stb = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    data_we_o      = beat;
    tag_we_o       = commit_stb;
    done_o         = commit_stb;
    rep_write_en_o = commit_stb;
    rep_way_hit_o  = commit_stb ? way_onehot : '0;
  end

  generate
    if (WORD_OFFSET_W > 0) begin : g_offset
      assign data_offset_o = cnt_q;
    end else begin : g_no_offset
      assign data_offset_o = '0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      index_q <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Directed bench for iob_cache_line_fill with hand-computed expectations.
module tb_iob_cache_line_fill;

  logic        clk_i = 1'b0;
  logic        cke_i, rst_i, miss_i;
  logic [19:0] miss_tag_i;
  logic [6:0]  miss_index_i;
  logic [2:0]  way_select_bin_i;
  logic        busy_o, done_o, be_valid_o;
  logic [28:0] be_addr_o;
  logic        be_ready_i, be_rvalid_i;
  logic [31:0] be_rdata_i;
  logic        data_we_o;
  logic [2:0]  data_way_o;
  logic [6:0]  data_index_o;
  logic [1:0]  data_offset_o;
  logic [31:0] data_wdata_o;
  logic        tag_we_o;
  logic [19:0] tag_o;
  logic        rep_write_en_o;
  logic [7:0]  rep_way_hit_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  iob_cache_line_fill dut (
    .clk_i            (clk_i),
    .cke_i            (cke_i),
    .rst_i            (rst_i),
    .miss_i           (miss_i),
    .miss_tag_i       (miss_tag_i),
    .miss_index_i     (miss_index_i),
    .way_select_bin_i (way_select_bin_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .be_valid_o       (be_valid_o),
    .be_addr_o        (be_addr_o),
    .be_ready_i       (be_ready_i),
    .be_rvalid_i      (be_rvalid_i),
    .be_rdata_i       (be_rdata_i),
    .data_we_o        (data_we_o),
    .data_way_o       (data_way_o),
    .data_index_o     (data_index_o),
    .data_offset_o    (data_offset_o),
    .data_wdata_o     (data_wdata_o),
    .tag_we_o         (tag_we_o),
    .tag_o            (tag_o),
    .rep_write_en_o   (rep_write_en_o),
    .rep_way_hit_o    (rep_way_hit_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [28:0] addr_of(input logic [19:0] t, input logic [6:0] idx);
    return {t, idx, 2'b00};
  endfunction

  task automatic check_commit(input string tag, input logic [7:0] hit, input logic [19:0] t);
    check({tag, "_tag_we"}, 64'(tag_we_o), 64'd1);
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_rep_we"}, 64'(rep_write_en_o), 64'd1);
    check({tag, "_rep_hit"}, 64'(rep_way_hit_o), 64'(hit));
    check({tag, "_tag_o"}, 64'(tag_o), 64'(t));
    check({tag, "_data_we"}, 64'(data_we_o), 64'd0);
  endtask

  initial begin
    cke_i = 1'b1; rst_i = 1'b1; miss_i = 1'b0;
    miss_tag_i = '0; miss_index_i = '0; way_select_bin_i = '0;
    be_ready_i = 1'b0; be_rvalid_i = 1'b0; be_rdata_i = '0;
    tick(); tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_be_valid", 64'(be_valid_o), 64'd0);
    check("rst_be_addr", 64'(be_addr_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_tag_o", 64'(tag_o), 64'd0);
    check("rst_way", 64'(data_way_o), 64'd0);

    // Basic fill: immediate ready, back-to-back beats.
    rst_i = 1'b0; miss_i = 1'b1; miss_tag_i = 20'h12345; miss_index_i = 7'h05;
    way_select_bin_i = 3'd3; be_ready_i = 1'b1;
    #1 check("idle_busy", 64'(busy_o), 64'd0);
    tick();
    miss_i = 1'b0;
    #1;
    check("req_valid", 64'(be_valid_o), 64'd1);
    check("req_addr", 64'(be_addr_o), 64'h2468A14);
    check("req_busy", 64'(busy_o), 64'd1);
    check("req_way", 64'(data_way_o), 64'd3);
    check("req_tag_o", 64'(tag_o), 64'h12345);
    check("req_no_we", 64'(data_we_o), 64'd0);
    tick();
    be_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      be_rvalid_i = 1'b1; be_rdata_i = 32'hA0 + 32'(i);
      #1;
      check("fill_we", 64'(data_we_o), 64'd1);
      check("fill_off", 64'(data_offset_o), 64'(i));
      check("fill_wdata", 64'(data_wdata_o), 64'(32'hA0 + 32'(i)));
      check("fill_way", 64'(data_way_o), 64'd3);
      check("fill_index", 64'(data_index_o), 64'h05);
      check("fill_no_done", 64'(done_o), 64'd0);
      tick();
    end
    be_rvalid_i = 1'b0;
    #1 check_commit("c1", 8'b00001000, 20'h12345);
    tick();
    check("c1_idle_busy", 64'(busy_o), 64'd0);
    check("c1_idle_done", 64'(done_o), 64'd0);

    // Stalled request, clock-enable hold in REQ, then gapped beats.
    miss_i = 1'b1; miss_tag_i = 20'hABCDE; miss_index_i = 7'h7F; way_select_bin_i = 3'd7;
    tick();
    miss_i = 1'b0; be_rvalid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", 64'(be_valid_o), 64'd1);
      check("stall_addr", 64'(be_addr_o), 64'(addr_of(20'hABCDE, 7'h7F)));
      check("stall_no_we", 64'(data_we_o), 64'd0);
      tick();
    end
    cke_i = 1'b0; be_ready_i = 1'b1;
    #1 check("cke_req_valid", 64'(be_valid_o), 64'd1);
    tick();
    cke_i = 1'b1; be_ready_i = 1'b0; be_rvalid_i = 1'b0;
    #1 check("cke_req_frozen", 64'(be_valid_o), 64'd1);
    be_ready_i = 1'b1;
    tick();
    be_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        be_rvalid_i = 1'b0;
        #1;
        check("gap_no_we", 64'(data_we_o), 64'd0);
        check("gap_off", 64'(data_offset_o), 64'(i));
        check("gap_busy", 64'(busy_o), 64'd1);
        tick();
      end
      be_rvalid_i = 1'b1; be_rdata_i = 32'hB0 + 32'(i);
      #1;
      check("gap_we", 64'(data_we_o), 64'd1);
      check("gap_beat_off", 64'(data_offset_o), 64'(i));
      tick();
    end
    be_rvalid_i = 1'b0;
    #1 check_commit("c2", 8'b10000000, 20'hABCDE);
    tick();

    // New miss during FILL is ignored; a held miss starts the next fill.
    miss_i = 1'b1; miss_tag_i = 20'h11111; miss_index_i = 7'h01; way_select_bin_i = 3'd1;
    be_ready_i = 1'b1;
    tick();
    tick();
    be_ready_i = 1'b0;
    miss_tag_i = 20'h22222; miss_index_i = 7'h02; way_select_bin_i = 3'd2;
    for (int i = 0; i < 4; i++) begin
      be_rvalid_i = 1'b1; be_rdata_i = 32'hC0 + 32'(i);
      #1;
      check("ign_we", 64'(data_we_o), 64'd1);
      check("ign_tag", 64'(tag_o), 64'h11111);
      check("ign_way", 64'(data_way_o), 64'd1);
      tick();
    end
    be_rvalid_i = 1'b0;
    #1 check_commit("c3", 8'b00000010, 20'h11111);
    tick();
    check("held_idle_busy", 64'(busy_o), 64'd0);
    tick();
    check("held_req_valid", 64'(be_valid_o), 64'd1);
    check("held_req_addr", 64'(be_addr_o), 64'(addr_of(20'h22222, 7'h02)));
    check("held_req_way", 64'(data_way_o), 64'd2);
    miss_i = 1'b0; be_ready_i = 1'b1;
    tick();
    be_ready_i = 1'b0;

    // Reset after two beats abandons the line.
    for (int i = 0; i < 2; i++) begin
      be_rvalid_i = 1'b1; be_rdata_i = 32'hD0 + 32'(i);
      #1 check("rf_we", 64'(data_we_o), 64'd1);
      tick();
    end
    rst_i = 1'b1; be_rdata_i = 32'hD2;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      be_rdata_i = 32'hD3 + 32'(i);
      #1;
      check("rf_busy", 64'(busy_o), 64'd0);
      check("rf_no_we", 64'(data_we_o), 64'd0);
      check("rf_no_tag_we", 64'(tag_we_o), 64'd0);
      check("rf_no_done", 64'(done_o), 64'd0);
      check("rf_tag_cleared", 64'(tag_o), 64'd0);
      tick();
    end
    be_rvalid_i = 1'b0;

    // Clock enable low mid-FILL and during COMMIT.
    miss_i = 1'b1; miss_tag_i = 20'h33333; miss_index_i = 7'h03; way_select_bin_i = 3'd5;
    be_ready_i = 1'b1;
    tick();
    miss_i = 1'b0;
    tick();
    be_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      be_rvalid_i = 1'b1; be_rdata_i = 32'hE0 + 32'(i);
      #1 check("ck_off", 64'(data_offset_o), 64'(i));
      tick();
    end
    cke_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ck_frozen_we", 64'(data_we_o), 64'd0);
      check("ck_frozen_off", 64'(data_offset_o), 64'd2);
      check("ck_frozen_busy", 64'(busy_o), 64'd1);
      tick();
    end
    cke_i = 1'b1;
    for (int i = 2; i < 4; i++) begin
      be_rdata_i = 32'hE0 + 32'(i);
      #1;
      check("ck_resume_we", 64'(data_we_o), 64'd1);
      check("ck_resume_off", 64'(data_offset_o), 64'(i));
      tick();
    end
    be_rvalid_i = 1'b0; cke_i = 1'b0;
    #1;
    check("ck_commit_done", 64'(done_o), 64'd0);
    check("ck_commit_tag_we", 64'(tag_we_o), 64'd0);
    check("ck_commit_hit", 64'(rep_way_hit_o), 64'd0);
    tick();
    cke_i = 1'b1;
    #1 check_commit("c4", 8'b00100000, 20'h33333);
    tick();
    check("end_busy", 64'(busy_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_cache_line_fill.md
IOB_CACHE_LINE_FILL -- requirements
Module: iob_cache_line_fill

Interface
REQ-001 SHALL have parameters: N_WAYS, 8, number of ways; NWAYS_W, $clog2(N_WAYS), way index width; SET_INDEX_W, 7, set index width; TAG_W, 20, tag width; WORD_OFFSET_W, 2, log2 words per line; DATA_W, 32, word width.
REQ-002 SHALL have ports, with BE_ADDR_W = TAG_W+SET_INDEX_W+WORD_OFFSET_W:
- clk_i  in  1  single clock; all logic on rising edge.
- cke_i  in  1  clock enable.
- rst_i  in  1  reset, synchronous, active-high.
- miss_i  in  1  line miss request.
- miss_tag_i  in  TAG_W  tag of missing line.
- miss_index_i  in  SET_INDEX_W  set of missing line.
- way_select_bin_i  in  NWAYS_W  victim way from replacement policy.
- busy_o  out  1  fill in progress.
- done_o  out  1  one-cycle fill-complete pulse.
- be_valid_o  out  1  backend burst read request.
- be_addr_o  out  BE_ADDR_W  backend line base word address.
- be_ready_i  in  1  backend accepts request.
- be_rvalid_i  in  1  backend read beat valid.
- be_rdata_i  in  DATA_W  backend read beat data.
- data_we_o  out  1  data memory write strobe.
- data_way_o  out  NWAYS_W  data memory way.
- data_index_o  out  SET_INDEX_W  data memory set.
- data_offset_o  out  WORD_OFFSET_W  word within line.
- data_wdata_o  out  DATA_W  word to write.
- tag_we_o  out  1  tag/valid write strobe for data_way_o/data_index_o.
- tag_o  out  TAG_W  tag to write.
- rep_write_en_o  out  1  replacement-policy update strobe.
- rep_way_hit_o  out  N_WAYS  one-hot filled way.

Function
REQ-003 SHALL implement FSM IDLE, REQ, FILL, COMMIT; state, latches and counter change only when cke_i=1.
REQ-004 IDLE: busy_o=0; on miss_i=1 latch tag, index, way, clear beat counter, go REQ (latency 1 cycle).
REQ-005 REQ: be_valid_o=1, be_addr_o={tag,index,WORD_OFFSET_W'b0} held stable until be_ready_i=1, then go FILL.
REQ-006 FILL: each cycle with be_rvalid_i=1: data_we_o=1 combinationally, data_wdata_o=be_rdata_i, data_offset_o=counter, counter+1; beat with counter=2**WORD_OFFSET_W-1 goes COMMIT; no wrap beyond.
REQ-007 COMMIT: exactly one cycle tag_we_o=1, rep_write_en_o=1, rep_way_hit_o=1<<way, done_o=1; then IDLE.
REQ-008 busy_o=1 in REQ, FILL, COMMIT.
REQ-009 miss_i ignored outside IDLE; miss_i still high in IDLE after COMMIT starts new fill.
REQ-010 be_rvalid_i outside FILL ignored; be_ready_i outside REQ ignored.
REQ-011 WORD_OFFSET_W=0: single beat goes directly to COMMIT.
REQ-012 cke_i=0: data_we_o, tag_we_o, rep_write_en_o, done_o forced 0; be_valid_o held.
REQ-013 data_way_o, data_index_o, tag_o SHALL show latched values whenever busy_o=1.

Reset
REQ-014 rst_i=1 at clock edge SHALL force IDLE, counter 0, latches 0, regardless of cke_i; all outputs 0 next cycle.
REQ-015 Reset mid-fill SHALL abandon line with no COMMIT strobes; late backend beats ignored.

Structure
REQ-016 State encodings SHALL live in shared iob_cache configuration header with other cache constants.
REQ-017 SHALL instantiate one sub-module, iob_cache_bin_to_onehot, producing rep_way_hit_o.

Verification
REQ-018 Miss tag=0x12345, index=0x05, way=3, be_ready_i immediate, beats 0xA0..0xA3 back-to-back -> be_addr_o=0x2468A14; data_we_o 4 cycles, offsets 0..3, data_way_o=3; next cycle tag_we_o, done_o, rep_way_hit_o=8'b00001000.
REQ-019 be_ready_i low 5 cycles -> be_valid_o and be_addr_o stable 5 cycles, no data_we_o.
REQ-020 Beats with 2-cycle gaps -> offset advances only on be_rvalid_i; COMMIT one cycle after 4th beat.
REQ-021 miss_i held with new tag during FILL -> ignored; next fill starts cycle after done_o with new tag.
REQ-022 rst_i after 2 beats -> busy_o=0 next cycle, no tag_we_o/done_o, remaining 2 beats produce no data_we_o.
REQ-023 cke_i low 3 cycles mid-FILL -> counter and state frozen, no strobes; fill completes normally after.
